// File: rtl/flopr_pipe_if.sv
// flopr_pipe_if: producer/consumer handshake bundle for flopr_pipe.
// The master drives upstream data and downstream ready. The pipeline is the slave.
interface flopr_pipe_if #(
   parameter int unsigned WIDTH = 4
);
   logic             i_flush;
   logic             i_valid;
   logic             o_ready;
   logic [WIDTH-1:0] i_d;
   logic             o_valid;
   logic             i_ready;
   logic [WIDTH-1:0] o_q;

   modport master (
      output i_flush, i_valid, i_d, i_ready,
      input  o_ready, o_valid, o_q
   );

   modport slave (
      input  i_flush, i_valid, i_d, i_ready,
      output o_ready, o_valid, o_q
   );
endinterface

// File: rtl/flopr_pipe.sv
// flopr_pipe: elastic DEPTH-stage resettable register pipeline with valid/ready and flush.
// Define FLOPR_PIPE_COUNT_EN to add the registered o_count occupancy output.
module flopr_pipe #(
   parameter int unsigned      WIDTH   = 4,
   parameter int unsigned      DEPTH   = 2,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic                       i_clk,
   input  logic                       i_reset_n,
`ifdef FLOPR_PIPE_COUNT_EN
   output logic [$clog2(DEPTH+1)-1:0] o_count,
`endif
   flopr_pipe_if.slave                bus
);

   logic [DEPTH-1:0] vld_p;
   logic [WIDTH-1:0] dat_p   [DEPTH];
   logic [DEPTH-1:0] stage_rdy;
   logic [DEPTH-1:0] src_vld;
   logic [WIDTH-1:0] src_dat [DEPTH];
   logic             tail_full;

   // A stage can load when it or any stage downstream of it has room, or the consumer drains
   always_comb begin
      tail_full = 1'b1;
      stage_rdy = '0;
      for (int k = int'(DEPTH) - 1; k >= 0; k--) begin
         tail_full    = tail_full & vld_p[k];
         stage_rdy[k] = bus.i_ready | ~tail_full;
      end
   end

   always_comb begin
      src_vld[0] = bus.i_valid;
      src_dat[0] = bus.i_d;
      for (int k = 1; k < int'(DEPTH); k++) begin
         src_vld[k] = vld_p[k-1];
         src_dat[k] = dat_p[k-1];
      end
   end

   // Stage registers: valids are cleared by flush, data only moves with a valid word
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         vld_p <= '0;
      end else if (bus.i_flush) begin
         vld_p <= '0;
      end else begin
         for (int k = 0; k < int'(DEPTH); k++) begin
            if (stage_rdy[k]) begin
               vld_p[k] <= src_vld[k];
            end
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         for (int k = 0; k < int'(DEPTH); k++) begin
            dat_p[k] <= RST_VAL;
         end
      end else if (!bus.i_flush) begin
         for (int k = 0; k < int'(DEPTH); k++) begin
            if (stage_rdy[k] && src_vld[k]) begin
               dat_p[k] <= src_dat[k];
            end
         end
      end
   end

   assign bus.o_valid = vld_p[DEPTH-1];
   assign bus.o_q     = dat_p[DEPTH-1];
   assign bus.o_ready = stage_rdy[0] & ~bus.i_flush;

`ifdef FLOPR_PIPE_COUNT_EN
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic             in_xfer;
   logic             out_xfer;
   logic [CNT_W-1:0] count_q;

   assign in_xfer  = bus.i_valid & bus.o_ready;
   assign out_xfer = bus.o_valid & bus.i_ready;

   // Occupancy tracks the number of set stage valids after each edge
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         count_q <= '0;
      end else if (bus.i_flush) begin
         count_q <= '0;
      end else if (in_xfer && !out_xfer) begin
         count_q <= count_q + 1'b1;
      end else if (out_xfer && !in_xfer) begin
         count_q <= count_q - 1'b1;
      end
   end

   assign o_count = count_q;

   always_ff @(posedge i_clk) begin
      if (i_reset_n) begin
         assert (int'(count_q) == $countones(vld_p))
           else $error("occupancy count disagrees with stage valids");
      end
   end
`endif

endmodule

// File: tb/tb_flopr_pipe.sv
// tb_flopr_pipe: directed and randomized checks of flopr_pipe (WIDTH=8, DEPTH=3)
// against a word/position queue model of the elastic pipeline.
module tb_flopr_pipe;
   localparam int W  = 8;
   localparam int D  = 3;
   localparam int CW = $clog2(D + 1);

   logic i_clk     = 1'b0;
   logic i_reset_n = 1'b1;
   always #5 i_clk = ~i_clk;

   flopr_pipe_if #(.WIDTH(W)) bus ();

`ifdef FLOPR_PIPE_COUNT_EN
   logic [CW-1:0] o_count;
`endif

   flopr_pipe #(
      .WIDTH   (W),
      .DEPTH   (D),
      .RST_VAL (8'h00)
   ) dut (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
`ifdef FLOPR_PIPE_COUNT_EN
      .o_count   (o_count),
`endif
      .bus       (bus)
   );

   int checks = 0;
   int errors = 0;

   // Model: queue of words in flight with their stage position (0 = input side)
   logic [W-1:0] md[$];
   int           mp[$];
   logic [W-1:0] got[$];

   logic         s_valid, s_ready, e_valid, e_ready;
   logic [W-1:0] s_q, e_q;
`ifdef FLOPR_PIPE_COUNT_EN
   int           s_count, e_count;
`endif

   // One clock: sample at negedge, predict, advance the model, return at posedge+1
   task automatic cycle();
      int   np[$];
      int   lim;
      logic leave;
      @(negedge i_clk);
      s_valid = bus.o_valid;
      s_ready = bus.o_ready;
      s_q     = bus.o_q;
`ifdef FLOPR_PIPE_COUNT_EN
      s_count = int'(o_count);
      e_count = mp.size();
`endif
      e_valid = (mp.size() > 0) && (mp[0] == D - 1);
      e_q     = e_valid ? md[0] : '0;
      leave   = e_valid && bus.i_ready && !bus.i_flush;
      lim     = D - 1;
      for (int i = 0; i < mp.size(); i++) begin
         if (i == 0 && leave) np.push_back(D);
         else np.push_back((mp[i] + 1 < lim) ? mp[i] + 1 : lim);
         lim = np[i] - 1;
      end
      e_ready = !bus.i_flush && (np.size() == 0 || np[np.size()-1] >= 1);
      if (s_valid && bus.i_ready && !bus.i_flush && i_reset_n) got.push_back(s_q);
      if (i_reset_n) begin
         if (bus.i_flush) begin
            md.delete();
            mp.delete();
         end else begin
            if (leave) begin
               md.delete(0);
               np.delete(0);
            end
            mp = np;
            if (bus.i_valid && e_ready) begin
               md.push_back(bus.i_d);
               mp.push_back(0);
            end
         end
      end
      @(posedge i_clk);
      #1;
   endtask

   task automatic settle();
      bus.i_valid = 1'b0;
      bus.i_flush = 1'b0;
      bus.i_ready = 1'b1;
      repeat (D + 2) cycle();
      got.delete();
   endtask

   task automatic drain(input int n, input string tag);
      int budget = 0;
      bus.i_valid = 1'b0;
      bus.i_flush = 1'b0;
      bus.i_ready = 1'b1;
      while (got.size() < n && budget < 20) begin
         cycle();
         budget++;
      end
      checks++;
      if (got.size() < n) begin
         errors++;
         $display("FAIL %s_drain words got %0d required %0d", tag, got.size(), n);
      end
   endtask

   task automatic test_reset();
      bus.i_valid = 1'b0;
      bus.i_flush = 1'b0;
      bus.i_ready = 1'b0;
      bus.i_d     = '0;
      #1 i_reset_n = 1'b0;
      #1;
      checks++;
      if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b required 0", bus.o_valid); end
      checks++;
      if (bus.o_q !== 8'h00) begin errors++; $display("FAIL reset_q got %h required 00", bus.o_q); end
      checks++;
      if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b required 1", bus.o_ready); end
`ifdef FLOPR_PIPE_COUNT_EN
      checks++;
      if (o_count !== '0) begin errors++; $display("FAIL reset_count got %0d required 0", o_count); end
`endif
      @(posedge i_clk);
      #1 i_reset_n = 1'b1;
      settle();
   endtask

   task automatic test_reset_midstream();
      settle();
      bus.i_ready = 1'b0;
      bus.i_valid = 1'b1;
      bus.i_d = 8'h11; cycle();
      bus.i_d = 8'h22; cycle();
      bus.i_valid = 1'b0;
      cycle();
      cycle();
      checks++;
      if (s_valid !== 1'b1 || s_q !== 8'h11) begin
         errors++; $display("FAIL rstmid_pre valid/q got %b/%h required 1/11", s_valid, s_q);
      end
      #3 i_reset_n = 1'b0;
      #1;
      checks++;
      if (bus.o_valid !== 1'b0 || bus.o_q !== 8'h00 || bus.o_ready !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_async valid/q/ready got %b/%h/%b required 0/00/1",
                  bus.o_valid, bus.o_q, bus.o_ready);
      end
      md.delete();
      mp.delete();
      @(posedge i_clk);
      #1 i_reset_n = 1'b1;
      bus.i_ready = 1'b1;
      bus.i_valid = 1'b1;
      bus.i_d     = 8'h33;
      cycle();
      drain(1, "rstmid");
      checks++;
      if (got.size() < 1 || got[0] !== 8'h33) begin
         errors++; $display("FAIL rstmid_first got %h required 33", (got.size() > 0) ? got[0] : 8'hxx);
      end
   endtask

   task automatic test_stream();
      int   first = -1;
      int   n = 0;
      logic rdy_low = 1'b0;
      settle();
      bus.i_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         bus.i_valid = 1'b1;
         bus.i_d     = 8'(8'hA1 + i);
         cycle();
         if (!s_ready) rdy_low = 1'b1;
         if (s_valid && first < 0) first = n;
         n++;
      end
      bus.i_valid = 1'b0;
      while (got.size() < 5 && n < 20) begin
         cycle();
         if (s_valid && first < 0) first = n;
         n++;
      end
      checks++;
      if (first != D) begin errors++; $display("FAIL stream_latency got %0d required %0d", first, D); end
      checks++;
      if (rdy_low) begin errors++; $display("FAIL stream_ready got 0 required 1"); end
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (got.size() <= i || got[i] !== 8'(8'hA1 + i)) begin
            errors++; $display("FAIL stream_word%0d got %h required %h", i,
                               (got.size() > i) ? got[i] : 8'hxx, 8'(8'hA1 + i));
         end
      end
   endtask

   task automatic test_fill();
      int idx = 0;
      int budget = 0;
      settle();
      bus.i_ready = 1'b0;
      repeat (6) begin
         bus.i_valid = 1'b1;
         bus.i_d     = 8'(idx + 1);
         cycle();
         if (s_ready) idx++;
      end
      checks++;
      if (idx != 3) begin errors++; $display("FAIL fill_accepted got %0d required 3", idx); end
      checks++;
      if (s_ready !== 1'b0 || s_valid !== 1'b1 || s_q !== 8'h01) begin
         errors++; $display("FAIL fill_hold ready/valid/q got %b/%b/%h required 0/1/01", s_ready, s_valid, s_q);
      end
      bus.i_ready = 1'b1;
      while (idx < 5 && budget < 20) begin
         bus.i_valid = 1'b1;
         bus.i_d     = 8'(idx + 1);
         cycle();
         if (s_ready) idx++;
         budget++;
      end
      drain(5, "fill");
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (got.size() <= i || got[i] !== 8'(i + 1)) begin
            errors++; $display("FAIL fill_word%0d got %h required %h", i,
                               (got.size() > i) ? got[i] : 8'hxx, 8'(i + 1));
         end
      end
   endtask

   task automatic test_bubble();
      int span = 0;
      settle();
      bus.i_ready = 1'b0;
      bus.i_valid = 1'b1; bus.i_d = 8'h10; cycle();
      bus.i_valid = 1'b0;                  cycle();
      bus.i_valid = 1'b1; bus.i_d = 8'h20; cycle();
      bus.i_d = 8'h30;                     cycle();
      checks++;
      if (s_ready !== 1'b1) begin errors++; $display("FAIL bubble_third_ready got %b required 1", s_ready); end
      bus.i_valid = 1'b0;
      cycle();
      checks++;
      if (s_ready !== 1'b0 || s_q !== 8'h10) begin
         errors++; $display("FAIL bubble_full ready/q got %b/%h required 0/10", s_ready, s_q);
      end
      bus.i_ready = 1'b1;
      while (got.size() < 3 && span < 10) begin
         cycle();
         span++;
      end
      checks++;
      if (span != 3) begin errors++; $display("FAIL bubble_b2b cycles got %0d required 3", span); end
      for (int i = 0; i < 3; i++) begin
         checks++;
         if (got.size() <= i || got[i] !== 8'(8'h10 * (i + 1))) begin
            errors++; $display("FAIL bubble_word%0d got %h required %h", i,
                               (got.size() > i) ? got[i] : 8'hxx, 8'(8'h10 * (i + 1)));
         end
      end
   endtask

   task automatic test_flush();
      settle();
      bus.i_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.i_valid = 1'b1;
         bus.i_d     = 8'(8'h41 + i);
         cycle();
      end
      bus.i_flush = 1'b1;
      bus.i_valid = 1'b1;
      bus.i_d     = 8'h77;
      cycle();
      checks++;
      if (s_ready !== 1'b0 || s_valid !== 1'b1) begin
         errors++; $display("FAIL flush_cycle ready/valid got %b/%b required 0/1", s_ready, s_valid);
      end
`ifdef FLOPR_PIPE_COUNT_EN
      checks++;
      if (s_count != 3) begin errors++; $display("FAIL flush_count_before got %0d required 3", s_count); end
`endif
      bus.i_flush = 1'b0;
      bus.i_valid = 1'b0;
      cycle();
      checks++;
      if (s_valid !== 1'b0 || s_q !== 8'h41) begin
         errors++; $display("FAIL flush_after valid/q got %b/%h required 0/41", s_valid, s_q);
      end
`ifdef FLOPR_PIPE_COUNT_EN
      checks++;
      if (s_count != 0) begin errors++; $display("FAIL flush_count_after got %0d required 0", s_count); end
`endif
      bus.i_ready = 1'b1;
      repeat (5) cycle();
      checks++;
      if (got.size() != 0 || s_q !== 8'h41) begin
         errors++; $display("FAIL flush_empty words/q got %0d/%h required 0/41", got.size(), s_q);
      end
   endtask

   task automatic test_full_inout();
      logic bad = 1'b0;
      settle();
      bus.i_ready = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         bus.i_valid = 1'b1;
         bus.i_d     = 8'(i);
         cycle();
      end
      bus.i_ready = 1'b1;
      for (int i = 4; i <= 8; i++) begin
         bus.i_valid = 1'b1;
         bus.i_d     = 8'(i);
         cycle();
         if (s_ready !== 1'b1 || s_valid !== 1'b1) bad = 1'b1;
`ifdef FLOPR_PIPE_COUNT_EN
         checks++;
         if (s_count != 3) begin errors++; $display("FAIL inout_count got %0d required 3", s_count); end
`endif
      end
      checks++;
      if (bad) begin errors++; $display("FAIL inout_stream ready/valid dropped while full"); end
      drain(8, "inout");
      for (int i = 0; i < 8; i++) begin
         checks++;
         if (got.size() <= i || got[i] !== 8'(i + 1)) begin
            errors++; $display("FAIL inout_word%0d got %h required %h", i,
                               (got.size() > i) ? got[i] : 8'hxx, 8'(i + 1));
         end
      end
   endtask

   task automatic test_random();
      settle();
      for (int n = 0; n < 400; n++) begin
         bus.i_valid = 1'($urandom_range(0, 1));
         bus.i_ready = ($urandom_range(0, 9) < 6);
         bus.i_flush = ($urandom_range(0, 24) == 0);
         bus.i_d     = 8'($urandom);
         cycle();
         checks++;
         if (s_valid !== e_valid || s_ready !== e_ready || (e_valid && s_q !== e_q)) begin
            errors++;
            $display("FAIL rand_model n=%0d valid/ready/q got %b/%b/%h required %b/%b/%h",
                     n, s_valid, s_ready, s_q, e_valid, e_ready, e_q);
         end
`ifdef FLOPR_PIPE_COUNT_EN
         checks++;
         if (s_count != e_count) begin
            errors++; $display("FAIL rand_count n=%0d got %0d required %0d", n, s_count, e_count);
         end
`endif
      end
   endtask

   initial begin
      test_reset();
      test_reset_midstream();
      test_stream();
      test_fill();
      test_bubble();
      test_flush();
      test_full_inout();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
